// File: rtl/uart_tx_drain.sv
// UART transmitter that drains a show-ahead FIFO one word per frame:
// start bit, DBIT data bits LSB first, optional parity, then the stop period.
module uart_tx_drain #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned OVS     = 16,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned PARITY  = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_tick,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_rd_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);
  localparam int unsigned MAXT   = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int unsigned CW     = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam int unsigned NW     = (DBIT > 1) ? $clog2(DBIT) : 1;
  // Mode 3 is not a valid parity setting and falls back to no parity.
  localparam bit          PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam bit          PAR_ODD = (PARITY == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   s_cnt, s_cnt_next;
  logic [NW-1:0]   n, n_next;
  logic [DBIT-1:0] b_reg, b_next, b_shift;
  logic            par_bit, par_next;
  logic            tx_next, done_next;

  assign b_shift = b_reg >> 1;

  // State and datapath registers; tx, tx_busy and tx_done_tick are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      s_cnt        <= '0;
      n            <= '0;
      b_reg        <= '0;
      par_bit      <= 1'b0;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      state        <= state_next;
      s_cnt        <= s_cnt_next;
      n            <= n_next;
      b_reg        <= b_next;
      par_bit      <= par_next;
      tx           <= tx_next;
      tx_busy      <= (state_next != IDLE);
      tx_done_tick <= done_next;
    end
  end

  // Next-state logic; fifo_rd is the only combinational output (one clk per pop).
  always_comb begin
    state_next = state;
    s_cnt_next = s_cnt;
    n_next     = n;
    b_next     = b_reg;
    par_next   = par_bit;
    tx_next    = tx;
    done_next  = 1'b0;
    fifo_rd    = 1'b0;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          fifo_rd    = rst_n;
          b_next     = fifo_rd_data;
          par_next   = PAR_ODD ? ~(^fifo_rd_data) : ^fifo_rd_data;
          s_cnt_next = '0;
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == CW'(OVS - 1)) begin
            s_cnt_next = '0;
            n_next     = '0;
            tx_next    = b_reg[0];
            state_next = DATA;
          end else begin
            s_cnt_next = s_cnt + CW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt == CW'(OVS - 1)) begin
            s_cnt_next = '0;
            b_next     = b_shift;
            if (n == NW'(DBIT - 1)) begin
              if (PAR_EN) begin
                tx_next    = par_bit;
                state_next = PAR;
              end else begin
                tx_next    = 1'b1;
                state_next = STOP;
              end
            end else begin
              n_next  = n + NW'(1);
              tx_next = b_shift[0];
            end
          end else begin
            s_cnt_next = s_cnt + CW'(1);
          end
        end
      end
      PAR: begin
        if (s_tick) begin
          if (s_cnt == CW'(OVS - 1)) begin
            s_cnt_next = '0;
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            s_cnt_next = s_cnt + CW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt == CW'(SB_TICK - 1)) begin
            s_cnt_next = '0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            s_cnt_next = s_cnt + CW'(1);
          end
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain: four instances (no/even/odd parity, two stop
// bits) each fed by a small show-ahead FIFO model; tx is checked every clock.
module tb_uart_tx_drain;
  localparam int NI = 4;

  logic          clk, rst_n, s_tick;
  logic [NI-1:0] fifo_empty, fifo_rd, tx, tx_busy, tx_done_tick;
  logic [7:0]    rd_data [NI];
  logic [7:0]    mem [NI][16];
  logic [3:0]    wp [NI] = '{default: 4'd0};
  logic [3:0]    rp [NI] = '{default: 4'd0};
  int            tick_per;
  int            ph;
  int            n_tests, n_fail;

  typedef struct {
    int         k;
    logic [7:0] word;
    int         per;
    logic [11:0] bits;
    int         nb;
    int         sb;
  } vec_t;

  vec_t vecs [8];

  uart_tx_drain #(.DBIT(8), .OVS(16), .SB_TICK(16), .PARITY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .fifo_empty(fifo_empty[0]),
    .fifo_rd_data(rd_data[0]), .fifo_rd(fifo_rd[0]), .tx(tx[0]),
    .tx_busy(tx_busy[0]), .tx_done_tick(tx_done_tick[0]));
  uart_tx_drain #(.DBIT(8), .OVS(16), .SB_TICK(16), .PARITY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .fifo_empty(fifo_empty[1]),
    .fifo_rd_data(rd_data[1]), .fifo_rd(fifo_rd[1]), .tx(tx[1]),
    .tx_busy(tx_busy[1]), .tx_done_tick(tx_done_tick[1]));
  uart_tx_drain #(.DBIT(8), .OVS(16), .SB_TICK(16), .PARITY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .fifo_empty(fifo_empty[2]),
    .fifo_rd_data(rd_data[2]), .fifo_rd(fifo_rd[2]), .tx(tx[2]),
    .tx_busy(tx_busy[2]), .tx_done_tick(tx_done_tick[2]));
  uart_tx_drain #(.DBIT(8), .OVS(16), .SB_TICK(32), .PARITY(0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .fifo_empty(fifo_empty[3]),
    .fifo_rd_data(rd_data[3]), .fifo_rd(fifo_rd[3]), .tx(tx[3]),
    .tx_busy(tx_busy[3]), .tx_done_tick(tx_done_tick[3]));

  // Show-ahead FIFO models
  for (genvar g = 0; g < NI; g++) begin : g_fifo
    assign fifo_empty[g] = (wp[g] == rp[g]);
    assign rd_data[g]    = mem[g][rp[g]];
  end

  always @(posedge clk)
    for (int i = 0; i < NI; i++)
      if (fifo_rd[i]) rp[i] <= rp[i] + 4'd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud tick: one pulse every tick_per clks, changing just after the rising edge
  initial begin
    s_tick = 1'b0;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      ph = ph + 1;
      if (ph >= tick_per) ph = 0;
      s_tick = (ph == 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic push(input int k, input logic [7:0] w);
    mem[k][wp[k]] = w;
    wp[k] = wp[k] + 4'd1;
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // Waits for the pop, then checks tx/busy/done/rd on every clk against a tick-count model.
  task automatic check_frame(input int k, input logic [11:0] bits, input int nb,
                             input int sb, input int per, input string nm);
    int   budget, consumed, total, errs, c, idx;
    logic exp_tx;
    bit   done_seen;
    budget    = 2000;
    errs      = 0;
    consumed  = 0;
    done_seen = 0;
    total     = (nb - 1) * 16 + sb;
    while (!fifo_rd[k] && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_tests++;
    if (!fifo_rd[k]) begin
      n_fail++;
      $display("FAIL %s_pop: fifo_rd stayed 0, required a pop", nm);
      return;
    end
    c = 0;
    while (!done_seen && c < total * per + 40) begin
      @(negedge clk);
      c++;
      if (consumed < total) begin
        idx = consumed / 16;
        if (idx > nb - 1) idx = nb - 1;
        exp_tx = bits[idx];
        if (tx[k] !== exp_tx || tx_busy[k] !== 1'b1 || tx_done_tick[k] !== 1'b0 ||
            fifo_rd[k] !== 1'b0) begin
          if (errs == 0)
            $display("FAIL %s clk %0d: tx=%b busy=%b done=%b rd=%b, required tx=%b busy=1 done=0 rd=0",
                     nm, c, tx[k], tx_busy[k], tx_done_tick[k], fifo_rd[k], exp_tx);
          errs++;
        end
        if (s_tick) consumed++;
      end else begin
        done_seen = 1;
        if (tx[k] !== 1'b1 || tx_busy[k] !== 1'b0 || tx_done_tick[k] !== 1'b1) begin
          $display("FAIL %s end clk %0d: tx=%b busy=%b done=%b, required tx=1 busy=0 done=1",
                   nm, c, tx[k], tx_busy[k], tx_done_tick[k]);
          errs++;
        end
      end
    end
    if (!done_seen) begin
      $display("FAIL %s_timeout: tx_done_tick=0 after %0d clks, required 1", nm, c);
      errs++;
    end
    if (errs != 0) n_fail++;
  endtask

  initial begin
    int rd_cnt, budget;
    n_tests  = 0;
    n_fail   = 0;
    tick_per = 1;
    rst_n    = 1'b0;

    vecs[0] = '{0, 8'hA5, 1, 12'h34A, 10, 16};
    vecs[1] = '{0, 8'h81, 5, 12'h302, 10, 16};
    vecs[2] = '{1, 8'h07, 1, 12'h60E, 11, 16};
    vecs[3] = '{2, 8'h07, 1, 12'h40E, 11, 16};
    vecs[4] = '{2, 8'h00, 1, 12'h600, 11, 16};
    vecs[5] = '{3, 8'h55, 1, 12'h2AA, 10, 32};
    vecs[6] = '{1, 8'h00, 1, 12'h400, 11, 16};
    vecs[7] = '{0, 8'h3C, 3, 12'h278, 10, 16};

    repeat (3) @(negedge clk);
    cmp("reset_tx", 32'(tx), 32'hF);
    cmp("reset_busy_done_rd", 32'({tx_busy, tx_done_tick, fifo_rd}), 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      tick_per = vecs[i].per;
      @(negedge clk);
      push(vecs[i].k, vecs[i].word);
      #1;
      check_frame(vecs[i].k, vecs[i].bits, vecs[i].nb, vecs[i].sb, vecs[i].per,
                  $sformatf("vec%0d", i));
      @(negedge clk);
      cmp($sformatf("vec%0d_done_width", i),
          32'({tx_done_tick[vecs[i].k], tx_busy[vecs[i].k], tx[vecs[i].k]}), 32'b001);
      repeat (3) @(negedge clk);
    end

    // Back-to-back frames with a single idle clk between stop and next start
    tick_per = 1;
    @(negedge clk);
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h3C);
    #1;
    check_frame(0, 12'h200, 10, 16, 1, "b2b0");
    cmp("b2b_gap0", 32'({fifo_rd[0], tx[0]}), 32'b11);
    check_frame(0, 12'h3FE, 10, 16, 1, "b2b1");
    cmp("b2b_gap1", 32'({fifo_rd[0], tx[0]}), 32'b11);
    check_frame(0, 12'h278, 10, 16, 1, "b2b2");
    cmp("b2b_empty", 32'(fifo_empty[0]), 32'h1);
    rd_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (fifo_rd[0]) rd_cnt++;
    end
    cmp("b2b_no_extra_rd", 32'(rd_cnt), 32'h0);

    // Reset in the middle of the third data bit
    @(negedge clk);
    push(0, 8'h5A);
    push(0, 8'h3C);
    #1;
    budget = 100;
    while (!fifo_rd[0] && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    cmp("rst_pop", 32'(fifo_rd[0]), 32'h1);
    repeat (56) @(negedge clk);
    cmp("rst_pre_tx", 32'(tx[0]), 32'h0);
    rst_n = 1'b0;
    #1;
    cmp("rst_tx_busy", 32'({tx[0], tx_busy[0]}), 32'b10);
    cmp("rst_rd_now", 32'(fifo_rd[0]), 32'h0);
    rd_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (fifo_rd[0]) rd_cnt++;
    end
    cmp("rst_rd_held", 32'(rd_cnt), 32'h0);
    cmp("rst_head_word", 32'(rd_data[0]), 32'h3C);
    rst_n = 1'b1;
    #1;
    check_frame(0, 12'h278, 10, 16, 1, "rst_next");
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_drain.md
Name: uart_tx_drain

Overview:
- UART transmitter that drains the TX-side fifo through its read port (rd, rd_data, empty).
- Whenever the FIFO is non-empty it pops one word and serialises it onto tx: start bit, DBIT data bits LSB first, optional parity bit, then stop bit(s).
- Bit timing comes from the shared oversampling baud tick s_tick, OVS ticks per bit.
- Sits between the stopwatch's TX fifo and the board UART TX pin.

Parameters:
- DBIT, 8, data bits per frame; equals fifo B.
- OVS, 16, s_tick pulses per data/start/parity bit.
- SB_TICK, 16, s_tick pulses for the stop period (16 = 1 stop bit, 32 = 2 stop bits).
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_tick  input  1  one-clk baud oversample pulse.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_data  input  DBIT  FIFO head word; show-ahead, valid whenever fifo_empty=0.
- fifo_rd  output  1  pop strobe to FIFO rd.
- tx  output  1  serial line, idle high.
- tx_busy  output  1  high in any state other than IDLE.
- tx_done_tick  output  1  one-clk pulse at end of stop period.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, tx=1, shift/tick/bit counters=0, tx_done_tick=0.
  - fifo_rd=0 while in reset.
  - Mid-frame reset aborts the frame; tx returns high immediately. The popped word is lost and is not re-popped.
- States: IDLE, START, DATA, PAR, STOP. tx is a register updated on the same edge as the state change.
- IDLE:
  - tx=1.
  - fifo_rd = (state==IDLE) && !fifo_empty, combinational, so exactly one clk per word.
  - On that edge: b_reg <= fifo_rd_data, s_cnt <= 0, tx <= 0, state <= START.
  - s_tick is ignored in IDLE.
- START: count s_tick. On s_tick with s_cnt==OVS-1: s_cnt<=0, n<=0, tx<=b_reg[0], state<=DATA.
- DATA:
  - On s_tick with s_cnt==OVS-1: b_reg shifts right, s_cnt<=0.
  - If n<DBIT-1: n<=n+1 and tx<=next bit.
  - If n==DBIT-1: go to PAR with tx<=parity (PARITY!=0), or go to STOP with tx<=1 (PARITY==0).
- Parity:
  - Computed over the word latched at pop, held in a register.
  - Even: parity bit = XOR of data. Odd: parity bit = ~XOR of data.
- PAR: OVS ticks, then tx<=1, s_cnt<=0, state<=STOP.
- STOP: on s_tick with s_cnt==SB_TICK-1: tx_done_tick=1 for that clk, state<=IDLE.
- Frame timing:
  - Frame length = (1+DBIT+(PARITY!=0))*OVS + SB_TICK ticks.
  - s_tick gaps stretch bits without corrupting them.
  - s_cnt only advances on s_tick.
- Back-to-back words:
  - The first clk in IDLE pops again if !fifo_empty.
  - Minimum inter-frame gap is one clk of tx=1 beyond the stop period. The line never glitches low.
- FIFO boundaries:
  - fifo_empty rising mid-frame has no effect.
  - fifo_rd is never asserted while fifo_empty=1. Underflow is impossible by construction.
- Counter widths: s_cnt is wide enough for max(OVS, SB_TICK)-1; n is clog2(DBIT) bits.
- Invalid configuration: PARITY=3 behaves as 0.

Test Plan:
- Single word, defaults, s_tick every clk: push 0xA5.
  - fifo_rd high exactly 1 clk.
  - tx = 0, then 1,0,1,0,0,1,0,1, then 1; each bit 16 clks.
  - tx_done_tick at clk 160 after the pop.
  - tx_busy high for 160 clks.
- Back-to-back: preload 0x00, 0xFF, 0x3C.
  - Three fifo_rd pulses, frames in order.
  - tx=1 gap of exactly 1 clk between stop and next start.
  - fifo_empty=1 after the third pop; no further rd.
- Sparse tick: s_tick once per 5 clks, word 0x81.
  - Each bit lasts 80 clks; bits 1,0,0,0,0,0,0,1.
  - No bit boundary occurs between ticks.
- Parity, PARITY=1 and PARITY=2, word 0x07.
  - Even: parity bit=1. Odd: parity bit=0.
  - Frame is 176 ticks.
  - PARITY=2 with 0x00: parity bit=1.
- Two stop bits, SB_TICK=32, word 0x55: stop high for 32 ticks; tx_done_tick 1 clk after the 32nd stop tick.
- Reset mid-DATA: assert rst_n=0 during bit 3 of 0x5A.
  - tx=1 and tx_busy=0 immediately; fifo_rd stays 0 during reset.
  - After release with the FIFO non-empty, the next word starts a clean frame with a full 16-tick start bit.
